// File: rtl/sine_dds_pkg.sv
// sine_dds_pkg: shared constants, quadrant type and quarter-wave magnitude table
package sine_dds_pkg;

    localparam int DATA_W    = 12;
    localparam int MIDSCALE  = 2048;
    localparam int LUT_DEPTH = 256;
    localparam int MAG_W     = 11;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_t;

    typedef logic [MAG_W-1:0] mag_rom_t [LUT_DEPTH];

    // Half-step offset keeps the folded wave symmetric about each quadrant edge
    function automatic mag_rom_t mag_rom_init();
        mag_rom_t t;
        for (int i = 0; i < LUT_DEPTH; i++)
            t[i] = MAG_W'($rtoi(2047.0 * $sin(3.14159265358979 / 2.0 * (real'(i) + 0.5) / real'(LUT_DEPTH)) + 0.5));
        return t;
    endfunction

endpackage

// File: rtl/sine_quarter_lut.sv
// sine_quarter_lut: synchronous quarter-wave magnitude ROM, one-cycle read latency
module sine_quarter_lut
    import sine_dds_pkg::*;
(
    input  logic                         clk,
    input  logic [$clog2(LUT_DEPTH)-1:0] addr,
    output logic [MAG_W-1:0]             mag
);

    localparam mag_rom_t ROM = mag_rom_init();

    always_ff @(posedge clk)
        mag <= ROM[addr];

endmodule

// File: rtl/sine_dds_source.sv
// sine_dds_source: DDS phase accumulator with quarter-wave folding feeding a 12-bit DAC
module sine_dds_source #(
    parameter int PHASE_W = 32,
    parameter int DATA_W  = 12,
    parameter int LUT_AW  = 8,
    parameter int DIV_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               sync,
    input  logic [PHASE_W-1:0] ftw,
    input  logic [DIV_W-1:0]   clk_div,
    output logic [DATA_W-1:0]  o_data,
    output logic               o_en
);

    import sine_dds_pkg::*;

    localparam logic [DATA_W-1:0] MID = DATA_W'(MIDSCALE);

    logic [DIV_W-1:0]    cnt;
    logic [PHASE_W-1:0]  phase;
    logic [LUT_AW+1:0]   s1_ph;
    logic                s1_v, s2_v, tick;
    quad_t               s1_q, s2_q;
    logic [LUT_AW-1:0]   idx, addr;
    logic [MAG_W-1:0]    mag;

    always_comb begin
        tick = run && cnt >= clk_div;
        s1_q = quad_t'(s1_ph[LUT_AW+1 -: 2]);
        idx  = s1_ph[LUT_AW-1:0];
        addr = (s1_q == Q1 || s1_q == Q3) ? ~idx : idx;
    end

    sine_quarter_lut u_lut (
        .clk  (clk),
        .addr (addr),
        .mag  (mag)
    );

    // sync outranks a same-cycle tick so no pre-sync phase can leak out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            phase  <= '0;
            s1_ph  <= '0;
            s1_v   <= 1'b0;
            s2_v   <= 1'b0;
            s2_q   <= Q0;
            o_data <= MID;
            o_en   <= 1'b0;
        end else if (sync) begin
            cnt   <= '0;
            phase <= '0;
            s1_v  <= 1'b0;
            s2_v  <= 1'b0;
            o_en  <= 1'b0;
        end else begin
            cnt  <= (tick || !run) ? '0 : cnt + 1'b1;
            s1_v <= tick;
            s2_v <= s1_v;
            s2_q <= s1_q;
            o_en <= s2_v;
            if (tick) begin
                s1_ph <= phase[PHASE_W-1 -: LUT_AW+2];
                phase <= phase + ftw;
            end
            if (s2_v)
                o_data <= (s2_q == Q0 || s2_q == Q1) ? MID + DATA_W'(mag) : MID - DATA_W'(mag);
        end
    end

endmodule

// File: tb/tb_sine_dds_source.sv
// tb_sine_dds_source: directed stimulus with a queue scoreboard checking strobe cycle and sample value
module tb_sine_dds_source;

    typedef struct {
        logic [11:0] d;
        bit          chk;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run, sync;
    logic [31:0] ftw;
    logic [15:0] clk_div;
    logic [11:0] o_data;
    logic        o_en;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   log_on = 1'b0;
    exp_t sb[$];
    int   cap[$];
    int   pat3[4] = '{2054, 4095, 2042, 1};

    sine_dds_source dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .sync    (sync),
        .ftw     (ftw),
        .clk_div (clk_div),
        .o_data  (o_data),
        .o_en    (o_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int d, input bit chk_d, input int c);
        exp_t e;
        e.d = 12'(d);
        e.chk = chk_d;
        e.c = c;
        sb.push_back(e);
    endtask

    task automatic chk(input string n, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", n, act, req);
        end
    endtask

    task automatic do_sync();
        sync = 1'b1;
        step();
        sync = 1'b0;
    endtask

    function automatic int exp4(input int k);
        case (k)
            0, 511, 1024: return 2054;
            1:            return 2067;
            255, 256:     return 4095;
            512, 1023:    return 2042;
            767, 768:     return 1;
            default:      return -1;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].c < cyc) begin
                checks++;
                failures++;
                $display("FAIL missed_strobe: no o_en at cycle %0d, expected data %0d", sb[0].c, sb[0].d);
                void'(sb.pop_front());
            end
            if (o_en) begin
                checks++;
                if (log_on) cap.push_back(int'(o_data));
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strobe: o_en at cycle %0d data %0d, expected none", cyc, o_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.c != cyc || (e.chk && o_data !== e.d)) begin
                        failures++;
                        $display("FAIL strobe: cycle %0d data %0d, expected cycle %0d data %0d", cyc, o_data, e.c, e.d);
                    end
                end
            end
        end
    end

    initial begin
        run = 1'b0; sync = 1'b0; ftw = '0; clk_div = '0;
        repeat (3) step();
        chk("reset_data", int'(o_data), 2048);
        chk("reset_en", int'(o_en), 0);
        rst_n = 1'b1;
        step();

        // constant phase 0
        do_sync();
        run = 1'b1;
        repeat (6) begin push(2054, 1, cyc + 3); step(); end
        run = 1'b0;
        repeat (5) step();

        // quarter-turn steps
        ftw = 32'h4000_0000;
        do_sync();
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin push(pat3[i % 4], 1, cyc + 3); step(); end
        run = 1'b0;
        repeat (5) step();

        // full sweep, one ROM step per sample, tick every 10 cycles
        clk_div = 16'd9;
        ftw = 32'h0040_0000;
        do_sync();
        run = 1'b1;
        log_on = 1'b1;
        for (int k = 0; k <= 1024; k++) begin
            int v;
            v = exp4(k);
            push(v < 0 ? 0 : v, v >= 0, cyc + 12);
            repeat (10) step();
        end
        run = 1'b0;
        repeat (5) step();
        log_on = 1'b0;
        chk("sweep_count", cap.size(), 1025);
        begin
            int bad;
            bad = 0;
            for (int i = 1; i < 256 && i < cap.size(); i++)
                if (cap[i] < cap[i-1]) bad++;
            chk("sweep_rising_violations", bad, 0);
        end

        // sync with samples in flight; the same-cycle tick is dropped
        clk_div = '0;
        ftw = 32'h4000_0000;
        do_sync();
        run = 1'b1;
        push(2054, 1, cyc + 3); step();
        push(4095, 1, cyc + 3); step();
        step();
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        push(2054, 1, cyc + 3); step();
        run = 1'b0;
        repeat (5) step();

        // clk_div lowered mid-count, then run dropped with a sample in flight
        clk_div = 16'd9;
        do_sync();
        run = 1'b1;
        repeat (4) step();
        clk_div = 16'd2;
        push(2054, 1, cyc + 3);
        repeat (3) step();
        push(4095, 1, cyc + 3);
        step();
        run = 1'b0;
        repeat (7) step();
        chk("hold_data", int'(o_data), 4095);
        chk("hold_en", int'(o_en), 0);
        run = 1'b1;
        push(2042, 1, cyc + 5);
        repeat (3) step();
        run = 1'b0;
        repeat (5) step();

        // asynchronous reset mid-run discards in-flight samples
        clk_div = '0;
        ftw = '0;
        do_sync();
        run = 1'b1;
        push(2054, 1, cyc + 3); step();
        push(2054, 1, cyc + 3); step();
        step();
        step();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_data", int'(o_data), 2048);
        chk("async_reset_en", int'(o_en), 0);
        step();
        rst_n = 1'b1;
        push(2054, 1, cyc + 3);
        step();
        run = 1'b0;
        repeat (6) step();

        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sine_dds_source.md
Name: sine_dds_source

Overview:
Direct-digital-synthesis sample source for the sine-wave project. It sits directly upstream of the 12-bit DAC stage and drives that stage's data bus and enable.
- A phase accumulator advances by a programmable tuning word on each sample tick.
- A quarter-wave magnitude ROM plus quadrant folding converts the phase to an offset-binary 12-bit sample.
- Each sample is presented with a one-cycle enable strobe that the DAC captures on the same clock edge.

Parameters:
PHASE_W, 32, phase accumulator and tuning-word width
DATA_W, 12, output sample width; must match the DAC data input
LUT_AW, 8, quarter-wave ROM address width (256 entries)
DIV_W, 16, sample-rate divider width

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
run  in  1  1 = generate ticks; 0 = stop issuing new samples
sync  in  1  one-cycle pulse: clear phase, divider and pipeline
ftw  in  PHASE_W  frequency tuning word, added to phase per tick
clk_div  in  DIV_W  tick every clk_div+1 cycles
o_data  out  DATA_W  offset-binary sample to DAC
o_en  out  1  one-cycle strobe, o_data valid in the same cycle

Behaviour:
- Reset (rst_n low, asynchronous) clears the following:
  - phase = 0, divider count = 0, all pipeline valid bits = 0.
  - o_data = 2048 (midscale), o_en = 0.
  - Asserting reset mid-operation discards in-flight samples immediately.
- Divider:
  - The count increments while run = 1.
  - A tick fires in the cycle where count >= clk_div; the count then returns to 0.
  - clk_div = 0 gives a tick every cycle.
  - Using >= makes a clk_div decrease mid-count tick at once rather than wait for a wrap.
  - With run = 0 the count holds at 0 and no ticks fire.
- Phase:
  - On a tick, stage 1 captures the current phase, then phase <= phase + ftw, modulo 2^PHASE_W.
  - The first sample after sync or reset therefore uses phase 0.
  - ftw changes take effect at the next tick.
- Address split:
  - q = phase[31:30] (quadrant).
  - idx = phase[29:22].
  - Remaining bits are truncated; no dithering.
- Folding:
  - q = 0 or 2: address = idx.
  - q = 1 or 3: address = ~idx (255 - idx).
- ROM:
  - mag[i] = round(2047 * sin(pi/2 * (i + 0.5) / 256)), 11-bit, range 6..2047.
  - Synchronous read, one-cycle latency.
- Output mapping:
  - q = 0 or 1: o_data = 2048 + mag.
  - q = 2 or 3: o_data = 2048 - mag.
  - Range 1..4095; no overflow is possible.
- Pipeline:
  - Stage 1 = phase capture, stage 2 = ROM read, stage 3 = output register.
  - o_en rises exactly 3 cycles after the tick cycle.
  - Each valid bit travels alongside its data.
- o_data holds its last value between strobes. o_en is never high for two consecutive cycles unless clk_div = 0.
- run falling: no new ticks are issued. Samples already in flight still complete and strobe; afterwards o_en stays 0 and o_data holds.
- sync:
  - On the next edge, phase, divider count and all valid bits clear to 0, so no pre-sync sample emerges.
  - o_data is not changed by sync.
  - sync has priority over a same-cycle tick; that tick is dropped.
- sync while run = 0 is legal and only clears state.

Decomposition:
- Package sine_dds_pkg holds:
  - DATA_W, MIDSCALE = 2048, LUT_DEPTH = 256, MAG_W = 11.
  - Quadrant typedef (enum Q0..Q3).
  - ROM init function computing the mag[] table.
- Sub-module sine_quarter_lut: synchronous 256 x 11 ROM with ports clk, addr, mag.
- Divider, accumulator, folding and output logic stay in sine_dds_source.

Test Plan:
1. rst_n low mid-run (async, between edges) -> o_data = 2048 and o_en = 0 immediately; no strobe until 3 cycles after the first post-reset tick.
2. sync, ftw = 0, clk_div = 0, run = 1 -> first o_en 3 cycles after run, then o_en every cycle, o_data = 2054 constant.
3. sync, ftw = 0x4000_0000, clk_div = 0 -> o_data sequence 2054, 4095, 2042, 1, repeating.
4. clk_div = 9, ftw = 0x0040_0000 -> o_en spacing exactly 10 cycles. Over 1024 samples:
   - samples 0-255 strictly non-decreasing;
   - peak 4095 at samples 255/256;
   - trough 1 at samples 767/768;
   - sample 1024 = 2054 (wrap).
5. sync pulsed while 3 samples are in flight (clk_div = 0) -> no o_en for the 3 cycles after sync; next sample = 2054. Same-cycle tick is dropped.
6. run dropped with samples in flight, and clk_div lowered from 9 to 2 mid-count -> in-flight samples strobe and then o_en stays 0 with o_data held. On run re-assertion, a tick fires when count >= 2.
